// File: rtl/lifo_stack_if.sv
// Bundled control/status signals for lifo_stack: push/pop/clear, top-of-stack,
// occupancy flags, indexed read port and sticky error flags.
interface lifo_stack_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic             clear;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             err_ovf;
  logic             err_udf;

  modport master (
    output clear, push, pop, in_data, rd_idx,
    input  out_data, empty, full, count, rd_data, err_ovf, err_udf
  );

  modport slave (
    input  clear, push, pop, in_data, rd_idx,
    output out_data, empty, full, count, rd_data, err_ovf, err_udf
  );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with replace-top, synchronous clear and indexed read.
// Optional sticky overflow/underflow flags enabled by defining STACK_ERR_EN.
module lifo_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6
) (
  input logic         clk,
  input logic         reset,
  lifo_stack_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] out_data_nxt_s;
  logic             empty_s;
  logic             full_s;
  logic             wr_en_s;
  logic [IDX_W-1:0] wr_addr_s;
  logic [IDX_W-1:0] top_idx_s;
  logic [IDX_W-1:0] below_top_s;

  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign full_s      = (count_r == CNT_W'(DEPTH));
  assign top_idx_s   = IDX_W'(count_r - CNT_W'(1));
  assign below_top_s = IDX_W'(count_r - CNT_W'(2));

  // Operation decode: write strobe, next occupancy and next top-of-stack
  always_comb begin
    count_nxt_s    = count_r;
    out_data_nxt_s = out_data_r;
    wr_en_s        = 1'b0;
    wr_addr_s      = IDX_W'(count_r);
    if (bus.push && bus.pop && !empty_s) begin
      wr_en_s        = 1'b1;
      wr_addr_s      = top_idx_s;
      out_data_nxt_s = bus.in_data;
    end else if (bus.push) begin
      // push&pop on an empty stack lands here and acts as a plain push
      if (!full_s) begin
        wr_en_s        = 1'b1;
        count_nxt_s    = count_r + CNT_W'(1);
        out_data_nxt_s = bus.in_data;
      end else begin
        count_nxt_s = count_r;
      end
    end else if (bus.pop) begin
      if (!empty_s) begin
        count_nxt_s = count_r - CNT_W'(1);
        if (count_r > CNT_W'(1)) begin
          out_data_nxt_s = mem_r[below_top_s];
        end else begin
          out_data_nxt_s = {WIDTH{1'b0}};
        end
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Occupancy and registered top-of-stack
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r    <= {CNT_W{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
    end else if (bus.clear) begin
      count_r    <= {CNT_W{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
    end else begin
      count_r    <= count_nxt_s;
      out_data_r <= out_data_nxt_s;
    end
  end

  // Entry storage; never reset, so stale contents are masked by count
  always_ff @(posedge clk) begin
    if (!reset && !bus.clear && wr_en_s) begin
      mem_r[wr_addr_s] <= bus.in_data;
    end
  end

  assign bus.out_data = out_data_r;
  assign bus.count    = count_r;
  assign bus.empty    = empty_s;
  assign bus.full     = full_s;
  assign bus.rd_data  = (CNT_W'(bus.rd_idx) < count_r) ? mem_r[bus.rd_idx]
                                                       : {WIDTH{1'b0}};

`ifdef STACK_ERR_EN
  logic ovf_ev_s;
  logic udf_ev_s;
  logic err_ovf_r;
  logic err_udf_r;

  assign ovf_ev_s = bus.push && !bus.pop && full_s;
  assign udf_ev_s = bus.pop && !bus.push && empty_s;

  // Sticky error flags; only reset clears them, clear leaves them alone
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf_r <= 1'b0;
      err_udf_r <= 1'b0;
    end else if (!bus.clear) begin
      if (ovf_ev_s) begin
        err_ovf_r <= 1'b1;
      end
      if (udf_ev_s) begin
        err_udf_r <= 1'b1;
      end
    end
  end

  assign bus.err_ovf = err_ovf_r;
  assign bus.err_udf = err_udf_r;
`else
  assign bus.err_ovf = 1'b0;
  assign bus.err_udf = 1'b0;
`endif
endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: a behavioural stack model queues expected
// status per cycle, each scenario task pops and compares after the edge.
module tb_lifo_stack;
  localparam int DEPTH = 8;
  localparam int WIDTH = 6;
  localparam int CNT_W = 4;
  localparam int IDX_W = 3;
`ifdef STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dout;
    logic             emp;
    logic             ful;
    logic             ovf;
    logic             udf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lifo_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  lifo_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t             exp_q[$];
  exp_t             e;
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_out = '0;
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;
  logic [WIDTH-1:0] exp_rd;

  // Drive one cycle of stimulus, advance the model, queue the expected status
  task automatic do_op(input logic rst, input logic clr, input logic ps,
                       input logic pp, input logic [WIDTH-1:0] d);
    reset = rst; bus.clear = clr; bus.push = ps; bus.pop = pp; bus.in_data = d;
    if (rst) begin
      m_cnt = 0; m_out = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (clr) begin
      m_cnt = 0; m_out = '0;
    end else if (ps && pp && m_cnt > 0) begin
      m_mem[m_cnt-1] = d; m_out = d;
    end else if (ps) begin
      if (m_cnt < DEPTH) begin
        m_mem[m_cnt] = d; m_cnt++; m_out = d;
      end else if (ERR_EN) m_ovf = 1'b1;
    end else if (pp) begin
      if (m_cnt > 0) begin
        m_cnt--; m_out = (m_cnt > 0) ? m_mem[m_cnt-1] : '0;
      end else if (ERR_EN) m_udf = 1'b1;
    end
    exp_q.push_back('{cnt: CNT_W'(m_cnt), dout: m_out, emp: (m_cnt == 0),
                      ful: (m_cnt == DEPTH), ovf: m_ovf, udf: m_udf});
    @(posedge clk); #1;
    reset = 1'b0; bus.clear = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      do_op((i < 2), 1'b0, 1'b0, 1'b0, '0);
      e = exp_q.pop_front(); checks++;
      if ({bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf} !== e) begin
        errors++; $display("FAIL reset[%0d]: got %h expected %h", i,
          {bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf}, e);
      end
    end
  endtask

  task automatic test_push();
    logic [WIDTH-1:0] vals [2];
    vals[0] = 6'o00; vals[1] = 6'o16;
    for (int i = 0; i < 2; i++) begin
      do_op(1'b0, 1'b0, 1'b1, 1'b0, vals[i]);
      e = exp_q.pop_front(); checks++;
      if ({bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf} !== e) begin
        errors++; $display("FAIL push[%0d]: got %h expected %h", i,
          {bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf}, e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      bus.rd_idx = IDX_W'(k); #1; checks++;
      exp_rd = (k < m_cnt) ? m_mem[k] : '0;
      if (bus.rd_data !== exp_rd) begin
        errors++; $display("FAIL push_rd[%0d]: got %h expected %h", k, bus.rd_data, exp_rd);
      end
    end
  endtask

  task automatic test_overflow();
    do_op(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 10; i++) begin
      // 1..8 fill, 9 overflows, 10 is a replace-top while full
      do_op(1'b0, 1'b0, 1'b1, (i == 10), WIDTH'(i));
      e = exp_q.pop_front(); checks++;
      if ({bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf} !== e) begin
        errors++; $display("FAIL overflow[%0d]: got %h expected %h", i,
          {bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf}, e);
      end
    end
    bus.rd_idx = 3'd7; #1; checks++;
    if (bus.rd_data !== m_mem[7]) begin
      errors++; $display("FAIL overflow_rd: got %h expected %h", bus.rd_data, m_mem[7]);
    end
  endtask

  task automatic test_replace();
    logic [WIDTH-1:0] vals [4];
    vals[0] = 6'd3; vals[1] = 6'd5; vals[2] = 6'd7; vals[3] = 6'd0;
    do_op(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 1'b0, 1'b1, (i == 2), vals[i]);
      e = exp_q.pop_front(); checks++;
      if ({bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf} !== e) begin
        errors++; $display("FAIL replace[%0d]: got %h expected %h", i,
          {bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf}, e);
      end
    end
    for (int k = 0; k < 2; k++) begin
      bus.rd_idx = IDX_W'(k); #1; checks++;
      if (bus.rd_data !== m_mem[k]) begin
        errors++; $display("FAIL replace_rd[%0d]: got %h expected %h", k, bus.rd_data, m_mem[k]);
      end
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 1'b0, 1'b0, 1'b1, '0);
      e = exp_q.pop_front(); checks++;
      if ({bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf} !== e) begin
        errors++; $display("FAIL underflow[%0d]: got %h expected %h", i,
          {bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf}, e);
      end
    end
    bus.rd_idx = 3'd0; #1; checks++;
    if (bus.rd_data !== 6'd0) begin
      errors++; $display("FAIL underflow_rd: got %h expected %h", bus.rd_data, 6'd0);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 6; i++) begin
      // four pushes, clear, then push&pop on the empty stack
      do_op(1'b0, (i == 4), (i != 4), (i == 5), WIDTH'(10 + i));
      e = exp_q.pop_front(); checks++;
      if ({bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf} !== e) begin
        errors++; $display("FAIL clear[%0d]: got %h expected %h", i,
          {bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    for (int i = 0; i < 400; i++) begin
      do_op(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, WIDTH'($urandom));
      e = exp_q.pop_front(); checks++;
      if ({bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf} !== e) begin
        errors++; $display("FAIL b2b[%0d]: got %h expected %h", i,
          {bus.count, bus.out_data, bus.empty, bus.full, bus.err_ovf, bus.err_udf}, e);
      end
      k = $urandom_range(0, DEPTH - 1);
      bus.rd_idx = IDX_W'(k); #1; checks++;
      exp_rd = (k < m_cnt) ? m_mem[k] : '0;
      if (bus.rd_data !== exp_rd) begin
        errors++; $display("FAIL b2b_rd[%0d]: got %h expected %h", i, bus.rd_data, exp_rd);
      end
    end
  endtask

  initial begin
    reset = 1'b1; bus.clear = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    bus.in_data = '0; bus.rd_idx = '0;
    test_reset();
    test_push();
    test_overflow();
    test_replace();
    test_underflow();
    test_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
